prog_loader: RTL

- Upstream boot stage for the 16-bit multicycle core.
- Receives a byte stream over a valid/ready handshake and assembles little-endian 16-bit words.
- Writes the words sequentially into the 64x16 instruction/data memory through that memory's write port (addr, we, wd).
- Holds the core in reset until the whole program is loaded, then releases it.

---
 rtl/prog_loader.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/prog_loader.sv
// Boot loader: assembles a little-endian byte stream into 16-bit words, writes them to memory, then releases the core.
// Define LOADER_CHECKSUM_EN to require a trailing mod-256 checksum byte.
module prog_loader #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wd,
    output logic              mem_we,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int               LEN_W   = ADDR_W + 1;
    localparam logic [7:0]       DEPTH_B = 8'(DEPTH);
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE, S_LEN, S_LO, S_HI, S_WRITE, S_CHK, S_DONE, S_ERR
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_LEN, S_LO, S_HI, S_WRITE, S_DONE, S_ERR
    } state_t;
`endif

    state_t           state, state_next;
    logic [LEN_W-1:0] len;
    logic             take, len_ok, last_word;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]       sum;
`endif

    assign take      = rx_valid && rx_ready;
    assign len_ok    = (rx_data != 8'd0) && (rx_data <= DEPTH_B);
    // Compared in LEN_W bits so a full-depth load ends on address DEPTH-1 without wrapping.
    assign last_word = ({1'b0, mem_addr} == (len - LEN_ONE));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        state_next = state;
        rx_ready   = 1'b0;
        mem_we     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        case (state)
            S_IDLE: if (start) state_next = S_LEN;
            S_LEN: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                if (take) state_next = len_ok ? S_LO : S_ERR;
            end
            S_LO: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                if (take) state_next = S_HI;
            end
            S_HI: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                if (take) state_next = S_WRITE;
            end
            S_WRITE: begin
                mem_we = 1'b1;
                busy   = 1'b1;
`ifdef LOADER_CHECKSUM_EN
                state_next = last_word ? S_CHK : S_LO;
`else
                state_next = last_word ? S_DONE : S_LO;
`endif
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHK: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                if (take) state_next = (rx_data == sum) ? S_DONE : S_ERR;
            end
`endif
            S_DONE: begin
                done = 1'b1;
                if (start) state_next = S_LEN;
            end
            S_ERR: begin
                err = 1'b1;
                if (start) state_next = S_LEN;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_addr  <= '0;
            mem_wd    <= '0;
            len       <= '0;
            cpu_reset <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
            sum       <= '0;
`endif
        end else begin
            // Core is released one cycle after DONE is entered; a new start re-holds it on the next edge.
            cpu_reset <= !((state == S_DONE) && !start);
            if (start && !busy) begin
                mem_addr <= '0;
`ifdef LOADER_CHECKSUM_EN
                sum      <= '0;
`endif
            end
            case (state)
                S_LEN: if (take && len_ok) len <= rx_data[LEN_W-1:0];
                S_LO: if (take) begin
                    mem_wd[7:0] <= rx_data;
`ifdef LOADER_CHECKSUM_EN
                    sum         <= sum + rx_data;
`endif
                end
                S_HI: if (take) begin
                    mem_wd[DATA_W-1:8] <= rx_data;
`ifdef LOADER_CHECKSUM_EN
                    sum                <= sum + rx_data;
`endif
                end
                S_WRITE: if (!last_word) mem_addr <= mem_addr + ADDR_W'(1);
                default: ;
            endcase
        end
    end

endmodule
